// File: rtl/adder_reg_arb.sv
// -----------------------------------------------------------------------------
// adder_reg_arb
//
// Round-robin arbiter and sequencer that time-shares one external adder_reg
// among NREQ requesters. A requester offers an operand pair with valid/ready.
// The winner's operands are latched and driven to the adder for one enable
// cycle. The registered sum is then captured and returned, tagged with the
// winner's id, over a valid/ready response port. After each response the
// adder is cleared for one cycle before the next grant.
//
// Ports
//   iClk        clock, rising edge
//   iRst        synchronous reset, active-high
//   iReqValid   per-requester request valid                 [NREQ]
//   oReqReady   one-hot accept, combinational in IDLE       [NREQ]
//   iReqData0   packed operand 0, requester i at [i*BITWIDTH +: BITWIDTH]
//   iReqData1   packed operand 1, same packing
//   oRespValid  response valid (registered)
//   iRespReady  response ready from consumer
//   oRespData   BITWIDTH+1 bit sum, carry preserved (registered)
//   oRespId     index of the requester owning the sum (registered)
//   oAddEn      adder enable, high for the one ISSUE cycle
//   oAddClr     adder clear, high for the one CLR cycle
//   oAddData0   adder operand 0 (registered, held outside ISSUE)
//   oAddData1   adder operand 1 (registered, held outside ISSUE)
//   iAddData    adder registered result, valid one cycle after oAddEn
//   oBusy       high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module adder_reg_arb #(
    parameter int BITWIDTH = 8,
    parameter int NREQ     = 4,
    parameter int IDW      = 2
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [NREQ-1:0]            iReqValid,
    output logic [NREQ-1:0]            oReqReady,
    input  logic [NREQ*BITWIDTH-1:0]   iReqData0,
    input  logic [NREQ*BITWIDTH-1:0]   iReqData1,
    output logic                       oRespValid,
    input  logic                       iRespReady,
    output logic [BITWIDTH:0]          oRespData,
    output logic [IDW-1:0]             oRespId,
    output logic                       oAddEn,
    output logic                       oAddClr,
    output logic [BITWIDTH-1:0]        oAddData0,
    output logic [BITWIDTH-1:0]        oAddData1,
    input  logic [BITWIDTH:0]          iAddData,
    output logic                       oBusy
);

    typedef enum logic [2:0] {
        CLR   = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } stateT;

    // One extra bit so rr + offset cannot overflow before the wrap.
    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    stateT          stateReg;
    stateT          stateNext;
    logic [IDW-1:0] rrReg;

    logic           grantFound;
    logic [IDW-1:0] grantIdx;
    logic           grantEn;
    logic [IDW:0]   cand;

    logic [BITWIDTH-1:0] reqOp0 [NREQ];
    logic [BITWIDTH-1:0] reqOp1 [NREQ];

    // Unpack operand buses and build the one-hot ready vector.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : gReq
            assign reqOp0[gi]    = iReqData0[gi*BITWIDTH +: BITWIDTH];
            assign reqOp1[gi]    = iReqData1[gi*BITWIDTH +: BITWIDTH];
            assign oReqReady[gi] = grantEn && (grantIdx == IDW'(gi));
        end
    endgenerate

    // Round-robin search starting at rrReg. The loop runs from the farthest
    // offset down to zero so the last hit, i.e. the nearest one, wins.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rrReg} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (iReqValid[cand[IDW-1:0]]) begin
                grantFound = 1'b1;
                grantIdx   = cand[IDW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg <= CLR;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state and strobe outputs. All strobes are forced low during
    // reset so nothing reaches the adder or the requesters while iRst is high.
    always_comb begin
        stateNext = stateReg;
        grantEn   = 1'b0;
        oAddEn    = 1'b0;
        oAddClr   = 1'b0;
        case (stateReg)
            CLR: begin
                oAddClr   = 1'b1;
                stateNext = IDLE;
            end
            IDLE: begin
                if (grantFound) begin
                    grantEn   = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                oAddEn    = 1'b1;
                stateNext = WAIT;
            end
            WAIT: begin
                stateNext = RESP;
            end
            RESP: begin
                if (iRespReady) begin
                    stateNext = CLR;
                end
            end
            default: begin
                stateNext = CLR;
            end
        endcase
        if (iRst) begin
            grantEn = 1'b0;
            oAddEn  = 1'b0;
            oAddClr = 1'b0;
        end
    end

    assign oBusy = (stateReg != IDLE);

    // Datapath: operand latch, round-robin pointer, response capture.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rrReg      <= '0;
            oAddData0  <= '0;
            oAddData1  <= '0;
            oRespId    <= '0;
            oRespData  <= '0;
            oRespValid <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (grantEn) begin
                        oAddData0 <= reqOp0[grantIdx];
                        oAddData1 <= reqOp1[grantIdx];
                        oRespId   <= grantIdx;
                        rrReg     <= (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
                    end
                end
                WAIT: begin
                    // The adder registered the sum on the ISSUE edge.
                    oRespData  <= iAddData;
                    oRespValid <= 1'b1;
                end
                RESP: begin
                    if (iRespReady) begin
                        oRespValid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_reg_arb.sv
module tb_adder_reg_arb;

    localparam int BW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     reqValid = '0;
    logic [NR-1:0]     reqReady;
    logic [NR*BW-1:0]  d0 = '0;
    logic [NR*BW-1:0]  d1 = '0;
    logic              respValid;
    logic              respReady = 1'b0;
    logic [BW:0]       respData;
    logic [IW-1:0]     respId;
    logic              addEn;
    logic              addClr;
    logic [BW-1:0]     addD0;
    logic [BW-1:0]     addD1;
    logic [BW:0]       addData = '0;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    adder_reg_arb #(.BITWIDTH(BW), .NREQ(NR), .IDW(IW)) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iReqValid  (reqValid),
        .oReqReady  (reqReady),
        .iReqData0  (d0),
        .iReqData1  (d1),
        .oRespValid (respValid),
        .iRespReady (respReady),
        .oRespData  (respData),
        .oRespId    (respId),
        .oAddEn     (addEn),
        .oAddClr    (addClr),
        .oAddData0  (addD0),
        .oAddData1  (addD1),
        .iAddData   (addData),
        .oBusy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder_reg: registered sum, one cycle after enable.
    always @(posedge clk) begin
        if (rst || addClr) addData <= '0;
        else if (addEn)    addData <= {1'b0, addD0} + {1'b0, addD1};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
        d0[i*BW +: BW] = a;
        d1[i*BW +: BW] = b;
    endtask

    // Waits up to 12 cycles for any grant; g stays 0 on timeout.
    task automatic wait_grant(output logic [NR-1:0] g, output int at);
        g  = '0;
        at = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (reqReady != '0) begin
                g  = reqReady;
                at = cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqValid = '1;
        tick();
        tick();
        checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL reset_respValid got %0b want 0", respValid); end
        checks++; if (respData !== 9'd0) begin errors++; $display("FAIL reset_respData got %0d want 0", respData); end
        checks++; if (respId !== 2'd0) begin errors++; $display("FAIL reset_respId got %0d want 0", respId); end
        checks++; if ({addD0, addD1} !== 16'd0) begin errors++; $display("FAIL reset_addData got %0d/%0d want 0/0", addD0, addD1); end
        checks++; if ({addEn, addClr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got en=%0b clr=%0b want 0/0", addEn, addClr); end
        checks++; if (reqReady !== 4'b0000) begin errors++; $display("FAIL reset_reqReady got %b want 0000", reqReady); end
        reqValid = '0;
        rst = 1'b0;
        #1;
        checks++; if ({addClr, addEn, busy} !== 3'b101) begin errors++; $display("FAIL clr_after_reset got clr=%0b en=%0b busy=%0b want 1/0/1", addClr, addEn, busy); end
        tick();
        checks++; if ({addClr, busy} !== 2'b00) begin errors++; $display("FAIL idle_after_clr got clr=%0b busy=%0b want 0/0", addClr, busy); end
        $display("reset done");
    endtask

    task automatic test_single();
        set_req(0, 8'd10, 8'd20);
        reqValid = 4'b0001;
        #1;
        checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", reqReady); end
        tick();
        reqValid = '0;
        #1;
        checks++; if (reqReady !== 4'b0000) begin errors++; $display("FAIL single_ready_pulse got %b want 0000", reqReady); end
        checks++; if ({addEn, addClr, addD0, addD1} !== {2'b10, 8'd10, 8'd20}) begin errors++; $display("FAIL single_issue got en=%0b clr=%0b a=%0d b=%0d want 1/0/10/20", addEn, addClr, addD0, addD1); end
        tick();
        checks++; if ({respValid, addEn} !== 2'b00) begin errors++; $display("FAIL single_wait got valid=%0b en=%0b want 0/0", respValid, addEn); end
        tick();
        checks++; if ({respValid, respData, respId} !== {1'b1, 9'd30, 2'd0}) begin errors++; $display("FAIL single_resp got v=%0b d=%0d id=%0d want 1/30/0", respValid, respData, respId); end
        $display("resp id=%0d data=%0d", respId, respData);
        respReady = 1'b1;
        tick();
        checks++; if ({respValid, addClr, addEn} !== 3'b010) begin errors++; $display("FAIL single_clr got v=%0b clr=%0b en=%0b want 0/1/0", respValid, addClr, addEn); end
        respReady = 1'b0;
        tick();
        checks++; if ({addClr, busy} !== 2'b00) begin errors++; $display("FAIL single_clr_once got clr=%0b busy=%0b want 0/0", addClr, busy); end
    endtask

    task automatic test_overflow();
        logic [NR-1:0] g;
        int at;
        set_req(2, 8'd255, 8'd255);
        reqValid = 4'b0100;
        wait_grant(g, at);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL ovf_grant got %b want 0100", g); end
        tick();
        reqValid = '0;
        tick();
        tick();
        checks++; if ({respValid, respData, respId} !== {1'b1, 9'd510, 2'd2}) begin errors++; $display("FAIL ovf_resp got v=%0b d=%0d id=%0d want 1/510/2", respValid, respData, respId); end
        $display("resp id=%0d data=%0d", respId, respData);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g;
        logic [NR-1:0] expG;
        int at;
        int prevAt;
        int e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NR; i++) set_req(i, 8'(i), 8'd100);
        reqValid  = 4'b1111;
        respReady = 1'b1;
        prevAt = 0;
        for (int n = 0; n < 5; n++) begin
            e = n % NR;
            expG = 4'b0001 << e;
            wait_grant(g, at);
            checks++; if (g !== expG) begin errors++; $display("FAIL rr_grant%0d got %b want %b", n, g, expG); end
            if (n > 0) begin
                checks++; if (at - prevAt !== 5) begin errors++; $display("FAIL rr_spacing%0d got %0d want 5", n, at - prevAt); end
            end
            prevAt = at;
            tick();
            tick();
            tick();
            checks++; if ({respValid, respData, respId} !== {1'b1, 9'(100 + e), 2'(e)}) begin errors++; $display("FAIL rr_resp%0d got v=%0b d=%0d id=%0d want 1/%0d/%0d", n, respValid, respData, respId, 100 + e, e); end
            $display("resp id=%0d data=%0d", respId, respData);
            tick();
        end
        reqValid  = '0;
        respReady = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [NR-1:0] g;
        int at;
        set_req(1, 8'd7, 8'd8);
        reqValid  = 4'b0010;
        respReady = 1'b0;
        wait_grant(g, at);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b want 0010", g); end
        tick();
        reqValid = '0;
        set_req(3, 8'd1, 8'd2);
        reqValid = 4'b1000;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({respValid, respData, respId, reqReady, addEn} !== {1'b1, 9'd15, 2'd1, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%0b d=%0d id=%0d rdy=%b en=%0b want 1/15/1/0000/0", i, respValid, respData, respId, reqReady, addEn);
            end
            tick();
        end
        $display("resp id=%0d data=%0d", respId, respData);
        respReady = 1'b1;
        tick();
        checks++; if ({respValid, addClr} !== 2'b01) begin errors++; $display("FAIL bp_release got v=%0b clr=%0b want 0/1", respValid, addClr); end
        respReady = 1'b0;
        tick();
        checks++; if (reqReady !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got %b want 1000", reqReady); end
        tick();
        reqValid = '0;
        tick();
        tick();
        checks++; if ({respValid, respData, respId} !== {1'b1, 9'd3, 2'd3}) begin errors++; $display("FAIL bp_next_resp got v=%0b d=%0d id=%0d want 1/3/3", respValid, respData, respId); end
        $display("resp id=%0d data=%0d", respId, respData);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        logic [NR-1:0] g;
        int at;
        set_req(1, 8'd5, 8'd6);
        reqValid = 4'b0010;
        wait_grant(g, at);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL mid_grant got %b want 0010", g); end
        tick();
        reqValid = '0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if ({respValid, addClr, addEn} !== 3'b000) begin errors++; $display("FAIL mid_in_reset got v=%0b clr=%0b en=%0b want 0/0/0", respValid, addClr, addEn); end
        rst = 1'b0;
        #1;
        checks++; if (addClr !== 1'b1) begin errors++; $display("FAIL mid_clr got %0b want 1", addClr); end
        set_req(0, 8'd9, 8'd9);
        set_req(2, 8'd40, 8'd2);
        reqValid  = 4'b0101;
        respReady = 1'b1;
        wait_grant(g, at);
        checks++; if ({g, respValid} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL mid_rr_zero got grant=%b v=%0b want 0001/0", g, respValid); end
        tick();
        reqValid = 4'b0100;
        tick();
        tick();
        checks++; if ({respData, respId} !== {9'd18, 2'd0}) begin errors++; $display("FAIL mid_resp0 got d=%0d id=%0d want 18/0", respData, respId); end
        $display("resp id=%0d data=%0d", respId, respData);
        tick();
        wait_grant(g, at);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL mid_grant2 got %b want 0100", g); end
        tick();
        reqValid = '0;
        tick();
        tick();
        checks++; if ({respValid, respData, respId} !== {1'b1, 9'd42, 2'd2}) begin errors++; $display("FAIL mid_resp2 got v=%0b d=%0d id=%0d want 1/42/2", respValid, respData, respId); end
        $display("resp id=%0d data=%0d", respId, respData);
        tick();
        respReady = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic [NR-1:0] g;
        logic [NR-1:0] expG;
        int at;
        int e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_req(0, 8'd50, 8'd50);
        set_req(1, 8'd1, 8'd1);
        set_req(3, 8'd3, 8'd3);
        reqValid  = 4'b1010;
        respReady = 1'b1;
        for (int n = 0; n < 4; n++) begin
            e = (n % 2 == 0) ? 1 : 3;
            expG = 4'b0001 << e;
            wait_grant(g, at);
            checks++; if (g !== expG) begin errors++; $display("FAIL fair_grant%0d got %b want %b", n, g, expG); end
            tick();
            tick();
            tick();
            checks++; if ({respData, respId} !== {9'(2 * e), 2'(e)}) begin errors++; $display("FAIL fair_resp%0d got d=%0d id=%0d want %0d/%0d", n, respData, respId, 2 * e, e); end
            $display("resp id=%0d data=%0d", respId, respData);
            tick();
        end
        reqValid  = '0;
        respReady = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
